// File: rtl/ysyx_25020047_lsu_ctrl.sv
// rtl/ysyx_25020047_lsu_ctrl.sv - multi-cycle load/store unit between execute and write-back
module ysyx_25020047_lsu_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        op_load,
   input  logic        op_store,
   input  logic [2:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic [31:0] memdata,
   output logic        err,
   output logic [1:0]  err_cause
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t      state;
   logic        is_store;
   logic [2:0]  sz;
   logic [1:0]  lo;
   logic [7:0]  cnt;

   logic        illegal, misal;
   logic [3:0]  st_mask;
   logic [31:0] st_data, shifted, ext;

   assign in_ready      = (state == IDLE) && !rst;
   assign mem_req_valid = (state == REQ);
   assign out_valid     = (state == DONE);

   // Decode of the operation presented by execute, used only on accept.
   always_comb begin
      illegal = 1'b0;
      if (op_store)
         illegal = size[2] || (size[1:0] == 2'b11);
      else
         illegal = (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
      misal   = ((size[1:0] == 2'b01) && addr[0]) || ((size[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      st_mask = 4'b1111;
      st_data = wdata;
      case (size[1:0])
         2'b00: begin
            st_mask = 4'b0001 << addr[1:0];
            st_data = {4{wdata[7:0]}};
         end
         2'b01: begin
            st_mask = addr[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane extraction uses the latched byte offset and size of the in-flight load.
   always_comb begin
      shifted = mem_rdata >> {lo, 3'b000};
      case (sz)
         3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ext = {24'd0, shifted[7:0]};
         3'b101:  ext = {16'd0, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         is_store  <= 1'b0;
         sz        <= 3'b000;
         lo        <= 2'b00;
         cnt       <= 8'd0;
         mem_addr  <= 32'd0;
         mem_wen   <= 1'b0;
         mem_wmask <= 4'b0000;
         mem_wdata <= 32'd0;
         memdata   <= 32'd0;
         err       <= 1'b0;
         err_cause <= 2'b00;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               is_store  <= op_store;
               sz        <= size;
               lo        <= addr[1:0];
               cnt       <= 8'd0;
               mem_addr  <= {addr[31:2], 2'b00};
               mem_wen   <= 1'b0;
               mem_wmask <= 4'b0000;
               mem_wdata <= 32'd0;
               memdata   <= 32'd0;
               err       <= 1'b0;
               err_cause <= 2'b00;
               if (!(op_load || op_store)) begin
                  state <= DONE;
               end else if (illegal) begin
                  state     <= DONE;
                  err       <= 1'b1;
                  err_cause <= 2'b11;
               end else if (misal) begin
                  state     <= DONE;
                  err       <= 1'b1;
                  err_cause <= 2'b01;
               end else begin
                  state     <= REQ;
                  mem_wen   <= op_store;
                  mem_wmask <= op_store ? st_mask : 4'b0000;
                  mem_wdata <= op_store ? st_data : 32'd0;
               end
            end
            REQ: begin
               cnt <= cnt + 8'd1;
               if (mem_req_ready) begin
                  state <= WAIT;
               end else if (cnt == TO) begin
                  state     <= DONE;
                  err       <= 1'b1;
                  err_cause <= 2'b10;
               end
            end
            WAIT: begin
               cnt <= cnt + 8'd1;
               if (mem_rsp_valid) begin
                  state   <= DONE;
                  memdata <= is_store ? 32'd0 : ext;
               end else if (cnt == TO) begin
                  state     <= DONE;
                  memdata   <= 32'd0;
                  err       <= 1'b1;
                  err_cause <= 2'b10;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
